// File: rtl/freq_meter_if.sv
// Measurement-side bundle for freq_meter: signal under test,
// run controls and the latched result.
interface freq_meter_if #(
    parameter int CNT_W = 20
);
    logic             sig_in;
    logic             start;
    logic             cont;
    logic             busy;
    logic             valid;
    logic [CNT_W-1:0] freq_count;
    logic             overflow;

    modport master (
        output sig_in, start, cont,
        input  busy, valid, freq_count, overflow
    );

    modport slave (
        input  sig_in, start, cont,
        output busy, valid, freq_count, overflow
    );
endinterface

// File: rtl/freq_meter.sv
// Counts rising edges of an asynchronous input over a fixed
// gate window of clk cycles; single-shot or continuous.
module freq_meter #(
    parameter int GATE_CYCLES = 1000000,
    parameter int CNT_W       = 20,
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    freq_meter_if.slave  bus
);
    localparam int GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    typedef enum logic [1:0] {
        IDLE,
        GATE,
        LATCH
    } state_t;

    state_t state, state_nx;

    logic [SYNC_STAGES-1:0] sync;
    logic                   hist;
    logic                   edge_p;

    logic [GW-1:0]    gate_cnt, gate_d;
    logic [CNT_W-1:0] edge_cnt, edge_d;
    logic             sat, sat_d;
    logic [CNT_W-1:0] freq_q, freq_d;
    logic             ovf_q, ovf_d;
    logic             busy_c, valid_c;

    assign edge_p = sync[SYNC_STAGES-1] & ~hist;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            sync     <= '0;
            hist     <= 1'b0;
            gate_cnt <= '0;
            edge_cnt <= '0;
            sat      <= 1'b0;
            freq_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state    <= state_nx;
            sync     <= {sync[SYNC_STAGES-2:0], bus.sig_in};
            hist     <= sync[SYNC_STAGES-1];
            gate_cnt <= gate_d;
            edge_cnt <= edge_d;
            sat      <= sat_d;
            freq_q   <= freq_d;
            ovf_q    <= ovf_d;
        end
    end

    always_comb begin
        state_nx = state;
        gate_d   = gate_cnt;
        edge_d   = edge_cnt;
        sat_d    = sat;
        freq_d   = freq_q;
        ovf_d    = ovf_q;
        busy_c   = 1'b0;
        valid_c  = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start || bus.cont) begin
                    state_nx = GATE;
                    gate_d   = '0;
                    edge_d   = '0;
                    sat_d    = 1'b0;
                end
            end
            GATE: begin
                busy_c = 1'b1;
                gate_d = gate_cnt + 1'b1;
                // An edge arriving at full scale is lost and flagged.
                if (edge_p) begin
                    if (edge_cnt == CNT_MAX) begin
                        sat_d = 1'b1;
                    end else begin
                        edge_d = edge_cnt + 1'b1;
                    end
                end
                if (gate_cnt == GATE_LAST) begin
                    state_nx = LATCH;
                    freq_d   = edge_d;
                    ovf_d    = sat_d;
                end
            end
            LATCH: begin
                busy_c  = 1'b1;
                valid_c = 1'b1;
                if (bus.cont) begin
                    state_nx = GATE;
                    gate_d   = '0;
                    edge_d   = '0;
                    sat_d    = 1'b0;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign bus.busy       = busy_c;
    assign bus.valid      = valid_c;
    assign bus.freq_count = freq_q;
    assign bus.overflow   = ovf_q;
endmodule

// File: tb/tb_freq_meter.sv
// Directed bench for freq_meter: two instances (8-bit and 4-bit
// counters, 100-cycle gate) driven from the same stimulus.
module tb_freq_meter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sig = 1'b0;
    logic start = 1'b0;
    logic cont = 1'b0;
    logic level = 1'b0;
    int   half = 0;
    int   ph = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    freq_meter_if #(.CNT_W(8)) b8 ();
    freq_meter_if #(.CNT_W(4)) b4 ();

    assign b8.sig_in = sig;
    assign b8.start  = start;
    assign b8.cont   = cont;
    assign b4.sig_in = sig;
    assign b4.start  = start;
    assign b4.cont   = cont;

    freq_meter #(.GATE_CYCLES(100), .CNT_W(8), .SYNC_STAGES(2)) u8 (
        .clk(clk), .rst_n(rst_n), .bus(b8.slave)
    );
    freq_meter #(.GATE_CYCLES(100), .CNT_W(4), .SYNC_STAGES(2)) u4 (
        .clk(clk), .rst_n(rst_n), .bus(b4.slave)
    );

    // half == 0: hold level; otherwise square wave of period 2*half
    initial begin
        forever begin
            @(negedge clk);
            if (half == 0) begin
                sig = level;
                ph = 0;
            end else begin
                ph++;
                if (ph >= half) begin
                    ph = 0;
                    sig = ~sig;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called on a negedge (cycle 0); returns the cycle valid was seen.
    task automatic run_one(output int vcyc, output int busy_bad);
        vcyc = -1;
        busy_bad = 0;
        start = 1'b1;
        for (int n = 1; n <= 300; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (b8.valid) begin
                vcyc = n;
                break;
            end
            if (!b8.busy) busy_bad++;
        end
    endtask

    initial begin
        int vc;
        int bb;
        int nv;
        int first;
        int vcs[3];

        repeat (3) @(negedge clk);
        check("rst_busy", 32'(b8.busy), 0);
        check("rst_valid", 32'(b8.valid), 0);
        check("rst_freq", 32'(b8.freq_count), 0);
        check("rst_ovf", 32'(b8.overflow), 0);
        rst_n = 1'b1;

        // 1: period 10
        half = 5;
        repeat (30) @(negedge clk);
        run_one(vc, bb);
        check("t1_latency", 32'(vc), 101);
        check("t1_busy_gaps", 32'(bb), 0);
        check("t1_freq8", 32'(b8.freq_count), 10);
        check("t1_ovf8", 32'(b8.overflow), 0);
        check("t1_valid4", 32'(b4.valid), 1);
        check("t1_freq4", 32'(b4.freq_count), 10);
        @(negedge clk);
        check("t1_valid_one", 32'(b8.valid), 0);
        check("t1_idle", 32'(b8.busy), 0);

        // 2: constant low, then constant high
        half = 0;
        level = 1'b0;
        repeat (20) @(negedge clk);
        run_one(vc, bb);
        check("t2_lat_low", 32'(vc), 101);
        check("t2_freq_low", 32'(b8.freq_count), 0);
        check("t2_ovf_low", 32'(b8.overflow), 0);
        level = 1'b1;
        repeat (20) @(negedge clk);
        run_one(vc, bb);
        check("t2_lat_high", 32'(vc), 101);
        check("t2_freq_high", 32'(b8.freq_count), 0);

        // 3: period 4 saturates the 4-bit counter
        half = 2;
        repeat (20) @(negedge clk);
        run_one(vc, bb);
        check("t3_lat", 32'(vc), 101);
        check("t3_freq8", 32'(b8.freq_count), 25);
        check("t3_ovf8", 32'(b8.overflow), 0);
        check("t3_freq4", 32'(b4.freq_count), 15);
        check("t3_ovf4", 32'(b4.overflow), 1);
        repeat (5) @(negedge clk);
        check("t3_hold_freq4", 32'(b4.freq_count), 15);
        check("t3_hold_ovf4", 32'(b4.overflow), 1);
        half = 5;
        repeat (20) @(negedge clk);
        run_one(vc, bb);
        check("t3_freq4_b", 32'(b4.freq_count), 10);
        check("t3_ovf4_b", 32'(b4.overflow), 0);

        // 4: continuous, period 20, cont dropped in third window
        half = 10;
        repeat (40) @(negedge clk);
        cont = 1'b1;
        nv = 0;
        for (int n = 1; n <= 600; n++) begin
            @(negedge clk);
            if (n == 250) cont = 1'b0;
            if (b8.valid) begin
                if (nv < 3) vcs[nv] = n;
                nv++;
                check("t4_freq", 32'(b8.freq_count), 5);
            end
            if (n == 304) check("t4_idle", 32'(b8.busy), 0);
        end
        check("t4_nvalid", 32'(nv), 3);
        check("t4_v1", 32'(vcs[0]), 101);
        check("t4_v2", 32'(vcs[1]), 202);
        check("t4_v3", 32'(vcs[2]), 303);

        // 5: start while busy ignored, then reset mid-gate
        half = 5;
        repeat (20) @(negedge clk);
        start = 1'b1;
        nv = 0;
        first = -1;
        for (int n = 1; n <= 300; n++) begin
            @(negedge clk);
            start = (n == 30 || n == 60);
            if (b8.valid) begin
                if (nv == 0) first = n;
                nv++;
            end
        end
        check("t5_nvalid", 32'(nv), 1);
        check("t5_vcyc", 32'(first), 101);
        check("t5_freq", 32'(b8.freq_count), 10);
        start = 1'b1;
        nv = 0;
        for (int n = 1; n <= 300; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (n == 50) begin
                rst_n = 1'b0;
                #1;
                check("t5_rst_busy", 32'(b8.busy), 0);
                check("t5_rst_valid", 32'(b8.valid), 0);
                check("t5_rst_freq", 32'(b8.freq_count), 0);
                check("t5_rst_ovf", 32'(b4.overflow), 0);
            end
            if (n == 52) rst_n = 1'b1;
            if (b8.valid) nv++;
        end
        check("t5_no_valid", 32'(nv), 0);
        run_one(vc, bb);
        check("t5_recover_lat", 32'(vc), 101);
        check("t5_recover_freq", 32'(b8.freq_count), 10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/freq_meter.md
Name: freq_meter

Overview:
Measures the frequency of an external, asynchronous square-wave signal by counting its rising edges over a fixed gate window timed in system-clock cycles. It is the measuring end of the clock-division path: the divider chain produces slow clocks, and this block counts them back to check or display their rate. The block supports single-shot and continuous measurement. The result is latched together with a one-cycle valid strobe and a saturation flag.

Parameters:
GATE_CYCLES, 1000000, gate window length in clk cycles (≥2)
CNT_W, 20, width of edge counter and result
SYNC_STAGES, 2, synchronizer flops on sig_in (≥2)

Ports:
clk  input  1  system clock; all logic on rising edge
rst_n  input  1  asynchronous active-low reset
sig_in  input  1  asynchronous signal to be measured
start  input  1  single-shot request; sampled only in IDLE
cont  input  1  continuous mode; sampled in IDLE and LATCH
busy  output  1  high in GATE and LATCH
valid  output  1  one-cycle strobe when freq_count/overflow update
freq_count  output  CNT_W  rising edges counted in last gate window
overflow  output  1  last window's edge count saturated

Behaviour:
- Reset (rst_n=0, asynchronous, any state): FSM→IDLE; sync flops, edge-history flop, gate counter, edge counter = 0; busy=0, valid=0, freq_count=0, overflow=0.
- Input path: sig_in passes through SYNC_STAGES flops, then one history flop. Edge pulse = synced & ~history, one clk wide. Edge pulses outside GATE are discarded.
- Input constraint: sig_in high and low phases each ≥2 clk periods. Faster inputs are undefined; no error is flagged.
- FSM states: IDLE, GATE, LATCH.
- IDLE: busy=0. If start=1 or cont=1 → GATE next cycle, with gate counter=0, edge counter=0, sat flag=0.
- GATE: gate counter +1 each cycle. Edge counter +1 on each edge pulse. At 2^CNT_W-1 the edge counter holds and sets the sat flag. An edge pulse in the final GATE cycle is counted. When gate counter = GATE_CYCLES-1 → LATCH. GATE lasts exactly GATE_CYCLES cycles.
- LATCH (1 cycle): valid=1; freq_count ← edge counter (with any final-cycle increment applied); overflow ← sat flag. Next state: if cont=1 → GATE with counters cleared; else → IDLE.
- Latency: start sampled at cycle 0 → GATE cycles 1..GATE_CYCLES → valid high in cycle GATE_CYCLES+1 with the new freq_count/overflow visible that cycle.
- Continuous mode: measurement period = GATE_CYCLES+1. Edges in the LATCH cycle are lost (one-cycle dead time by design).
- start while busy is ignored; it is not queued. Deasserting cont mid-window finishes the current window, then returns to IDLE.
- freq_count/overflow hold between valid strobes. valid is never high for 2 consecutive cycles.
- Reset mid-GATE or mid-LATCH discards the measurement; no valid is emitted.

Test Plan:
1. GATE_CYCLES=100, CNT_W=8; sig_in period 10 clk (5H/5L); 1-cycle start at cycle 0 → busy 1..101, valid only at cycle 101, freq_count=10, overflow=0, then IDLE.
2. sig_in held 0, start → valid at cycle 101, freq_count=0, overflow=0. Then sig_in held 1 and start again → freq_count=0 (no rising edges).
3. CNT_W=4, GATE_CYCLES=100, sig_in period 4 clk (2H/2L), start → freq_count=15, overflow=1. Next run with period 10 → freq_count=10, overflow=0.
4. cont=1 held, sig_in period 20 → valid every 101 cycles, each freq_count=5. Drop cont mid-third window → third result delivered, then busy=0 and no further valid.
5. Start a measurement, pulse start again at cycles 30 and 60 → single valid at 101. Assert rst_n=0 at cycle 50 → busy/valid/freq_count/overflow=0 immediately, no valid after release until a new start.
